// File: rtl/servo_pkg.sv
// Shared types and angle arithmetic for the servo slew-rate limiter.
package servo_pkg;

    typedef logic [7:0] angle_t;

    localparam angle_t MAX_ANGLE  = 8'd180;
    localparam angle_t HOME_ANGLE = 8'd90;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        PAUSE = 2'd2
    } ramp_state_t;

    function automatic angle_t clamp_angle(input angle_t a);
        return (a > MAX_ANGLE) ? MAX_ANGLE : a;
    endfunction

    // Move cur toward tgt by at most step; the 9-bit difference keeps the
    // comparison free of wrap so the result never passes the target.
    function automatic angle_t step_toward(input angle_t cur, input angle_t tgt,
                                           input angle_t step);
        logic [8:0] diff;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return cur + ((diff > {1'b0, step}) ? step : diff[7:0]);
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            return cur - ((diff > {1'b0, step}) ? step : diff[7:0]);
        end
        return cur;
    endfunction

endpackage

// File: rtl/servo_angle_ramp_if.sv
// Target/angle bus between the angle latch, the ramp limiter and the PWM generator.
interface servo_angle_ramp_if;
    import servo_pkg::*;

    logic       frame_tick;
    logic       enable;
    angle_t     target_angle1;
    angle_t     target_angle2;
    angle_t     target_angle3;
    angle_t     target_angle4;
    angle_t     angle1;
    angle_t     angle2;
    angle_t     angle3;
    angle_t     angle4;
    logic [3:0] moving;
    logic       all_settled;

    modport master (
        output frame_tick, enable,
        output target_angle1, target_angle2, target_angle3, target_angle4,
        input  angle1, angle2, angle3, angle4, moving, all_settled
    );

    modport slave (
        input  frame_tick, enable,
        input  target_angle1, target_angle2, target_angle3, target_angle4,
        output angle1, angle2, angle3, angle4, moving, all_settled
    );

endinterface

// File: rtl/servo_ramp_channel.sv
// One servo channel: clamps its target, steps its angle on step_strobe, flags mismatch.
module servo_ramp_channel
    import servo_pkg::*;
#(
    parameter angle_t STEP = 8'd1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   step_strobe,
    input  angle_t target,
    output angle_t angle,
    output logic   moving
);

    angle_t tgt_c;
    angle_t cur_d, cur_q;
    logic   moving_d, moving_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        tgt_c = clamp_angle(target);
        cur_d = cur_q;
        if (step_strobe) begin
            cur_d = step_toward(cur_q, tgt_c, STEP);
        end
        moving_d = (cur_d != tgt_c);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            cur_q    <= HOME_ANGLE;
            moving_q <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            moving_q <= moving_d;
        end
    end

    assign angle  = cur_q;
    assign moving = moving_q;

endmodule

// File: rtl/servo_angle_ramp.sv
// Slew-rate limiter: steps four servo angles toward their targets every FRAMES_PER_STEP PWM frames.
module servo_angle_ramp
    import servo_pkg::*;
#(
    parameter int unsigned STEP_DEG        = 1,
    parameter int unsigned FRAMES_PER_STEP = 1
) (
    input logic               clk,
    input logic               rst,
    servo_angle_ramp_if.slave bus
);

    localparam angle_t     STEP_A   = angle_t'(STEP_DEG);
    localparam logic [7:0] LAST_CNT = 8'(FRAMES_PER_STEP - 1);

    ramp_state_t state_d, state_q;
    logic [7:0]  frame_cnt_d, frame_cnt_q;
    logic        step_strobe;

    angle_t      tgt [4];
    angle_t      ang [4];
    logic [3:0]  mov;
    logic [3:0]  mismatch;
    logic [3:0]  lands;

    assign tgt[0] = bus.target_angle1;
    assign tgt[1] = bus.target_angle2;
    assign tgt[2] = bus.target_angle3;
    assign tgt[3] = bus.target_angle4;

    for (genvar i = 0; i < 4; i++) begin : gen_ch
        servo_ramp_channel #(.STEP(STEP_A)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .step_strobe(step_strobe),
            .target     (tgt[i]),
            .angle      (ang[i]),
            .moving     (mov[i])
        );
    end

    // lands[i]: a step taken now would leave channel i exactly on its target.
    always_comb begin
        mismatch = '0;
        lands    = '0;
        for (int i = 0; i < 4; i++) begin
            mismatch[i] = (ang[i] != clamp_angle(tgt[i]));
            lands[i]    = (step_toward(ang[i], clamp_angle(tgt[i]), STEP_A) == clamp_angle(tgt[i]));
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        step_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && |mismatch) begin
                    state_d     = RAMP;
                    frame_cnt_d = '0;
                end
            end
            RAMP: begin
                if (!bus.enable) begin
                    state_d = PAUSE;
                end else if (bus.frame_tick) begin
                    if (frame_cnt_q == LAST_CNT) begin
                        step_strobe = 1'b1;
                        frame_cnt_d = '0;
                        if (&lands) begin
                            state_d = IDLE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            PAUSE: begin
                if (bus.enable) begin
                    state_d = RAMP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.angle1      = ang[0];
    assign bus.angle2      = ang[1];
    assign bus.angle3      = ang[2];
    assign bus.angle4      = ang[3];
    assign bus.moving      = mov;
    assign bus.all_settled = ~|mov;

endmodule
